instruction_memory_sync: RTL

INSTRUCTION_MEMORY_SYNC -- requirements
Module: instruction_memory_sync

---
 rtl/instruction_memory_sync_if.sv | 26 ++
 rtl/instruction_memory_sync.sv | 85 ++++++++
 2 files changed

// File: rtl/instruction_memory_sync_if.sv
// Fetch/load bus for the synchronous instruction memory.
// master drives requests and load data; slave returns the registered fetch result.
interface instruction_memory_sync_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           Address;
    logic                  ReadEn;
    logic                  Stall;
    logic                  LoadEn;
    logic [31:0]           LoadAddr;
    logic [DATA_WIDTH-1:0] LoadData;
    logic [DATA_WIDTH-1:0] Instruction;
    logic                  Valid;
    logic                  AddrError;
    logic                  Ready;

    modport master (
        output Address, ReadEn, Stall, LoadEn, LoadAddr, LoadData,
        input  Instruction, Valid, AddrError, Ready
    );

    modport slave (
        input  Address, ReadEn, Stall, LoadEn, LoadAddr, LoadData,
        output Instruction, Valid, AddrError, Ready
    );
endinterface

// File: rtl/instruction_memory_sync.sv
// Word-addressed instruction memory with a registered fetch port, a program-load
// write port and a self-initialising fill sequence run after every reset.
module instruction_memory_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int INIT_MODE  = 0
) (
    input logic                  Clk,
    input logic                  Rst,
    instruction_memory_sync_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]            state;
    logic [AW-1:0]         init_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         fetch_idx;
    logic [AW-1:0]         load_idx;
    logic                  fetch_legal;
    logic                  load_ok;
    logic [DATA_WIDTH-1:0] init_word;

    always_comb begin
        fetch_idx   = bus.Address[AW+1:2];
        load_idx    = bus.LoadAddr[AW+1:2];
        fetch_legal = (bus.Address[1:0] == 2'b00) && !(|bus.Address[31:AW+2]);
        load_ok     = (state == RUN) && bus.LoadEn
                      && (bus.LoadAddr[1:0] == 2'b00) && !(|bus.LoadAddr[31:AW+2]);
        init_word   = '0;
        if (INIT_MODE == 1)
            init_word = DATA_WIDTH'({init_cnt, 2'b00});
    end

    assign bus.Ready = (state == RUN);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= INIT;
            init_cnt        <= '0;
            bus.Instruction <= '0;
            bus.Valid       <= 1'b0;
            bus.AddrError   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == AW'(DEPTH - 1))
                        state <= RUN;
                end
                default: begin
                    if (!bus.Stall) begin
                        if (bus.ReadEn) begin
                            bus.Valid <= 1'b1;
                            if (fetch_legal) begin
                                // Write-first: a same-cycle load to the fetched word wins.
                                bus.Instruction <= (load_ok && load_idx == fetch_idx)
                                                   ? bus.LoadData : mem[fetch_idx];
                                bus.AddrError   <= 1'b0;
                            end else begin
                                bus.Instruction <= '0;
                                bus.AddrError   <= 1'b1;
                            end
                        end else begin
                            bus.Valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Single write port shared by the fill sequence and program loads.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (state == INIT)
                mem[init_cnt] <= init_word;
            else if (load_ok)
                mem[load_idx] <= bus.LoadData;
        end
    end
endmodule
